char_uart_tx: RTL
=================

CHAR_UART_TX -- requirements
Module: char_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the character FIFO depth; power of 2, range 2..64.
REQ-003 Parameter CHANGE_ONLY, default 1: when 1, enqueue only on char_changed; when 0, enqueue on every char_valid.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 char_in  input  8  decoded ASCII character from the spike decoder.
REQ-007 char_valid  input  1  one-cycle strobe; char_in is valid.
REQ-008 char_changed  input  1  one-cycle strobe, coincident with char_valid when the character differs from the previous one.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 uart_tx  output  1  serial line, idle high, LSB first.
REQ-011 tx_busy  output  1  high while a frame is on the line (any state except IDLE).
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued characters.
REQ-013 overflow  output  1  sticky; a character was dropped.

Function
REQ-014 Push condition SHALL be char_valid && (CHANGE_ONLY ? char_changed : 1); char_changed without char_valid is ignored.
REQ-015 Push SHALL write char_in at that clock edge, and fifo_count SHALL increment at the same edge.
REQ-016 FSM states SHALL be IDLE, START, DATA, [PARITY], STOP; all outputs registered.
REQ-017 In IDLE with fifo_count>0, the next edge SHALL pop the head into the shift register and enter START; uart_tx drops low at that edge.
REQ-018 Latency from the push edge to the falling edge of uart_tx SHALL be exactly 1 clock when the FIFO was empty and the FSM was IDLE.
REQ-019 Each state SHALL hold its bit for exactly CLKS_PER_BIT cycles using a baud counter that reloads on every bit boundary.
REQ-020 DATA SHALL send bits 0..7 LSB first; STOP drives 1 for one bit time, then returns to IDLE.
REQ-021 Back-to-back frames: if the FIFO is non-empty at the end of STOP, the FSM SHALL pass through IDLE for exactly one cycle, then START.
REQ-022 Full FIFO plus push without pop: the character SHALL be dropped, overflow set to 1, and FIFO contents left unchanged.
REQ-023 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; fifo_count is unchanged.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL derive from fifo_count.
REQ-025 ovf_clr and an overflow event in the same cycle: overflow SHALL stay 1 (set wins).

Reset
REQ-026 With rst_n low at a clock edge, the block SHALL set: state IDLE, uart_tx=1, tx_busy=0, fifo_count=0, overflow=0, pointers=0, baud and bit counters=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (line high at the next edge) and discard FIFO contents.

Configuration
REQ-028 Macro CHAR_UART_TX_PARITY_EN, when defined, SHALL insert a PARITY state after DATA that sends even parity (XOR of the 8 data bits) for one bit time, giving an 11-bit frame.
REQ-029 Without CHAR_UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, giving a 10-bit frame.

Structure
REQ-030 Shared package hnsn_pkg SHALL hold the FSM state typedef, the ASCII constants (CHAR_SPACE=8'h20, CHAR_UNKNOWN=8'h3F) and the default CLKS_PER_BIT.
REQ-031 The FIFO SHALL be a sub-module char_fifo (parameter DEPTH; push/pop/full/empty/count ports); serializer and FSM stay in char_uart_tx.

Verification
REQ-032 CLKS_PER_BIT=4, no parity, push 8'h45 once -> uart_tx low 1 cycle after the push, then bits 1,0,1,0,0,0,1,0,stop=1, each 4 cycles; 40 cycles total; tx_busy high for 40 cycles.
REQ-033 Parity build, push 8'h45 -> parity bit=1 after data, 44-cycle frame; push 8'h46 -> parity bit=1; push 8'h41 -> parity bit=0.
REQ-034 CHANGE_ONLY=1: char_valid pulses 5x with 'E' and char_changed only on the first -> exactly one frame sent.
REQ-035 FIFO_DEPTH=4, 6 pushes on consecutive cycles while idle -> first pops at once, 4 queued, 1 dropped; overflow=1; ovf_clr clears it; 5 frames emitted in order.
REQ-036 Assert rst_n low mid-DATA of frame 2 with 3 queued -> uart_tx=1 and fifo_count=0 next edge; no further frames without new pushes.
REQ-037 Full FIFO, push on the same cycle as an IDLE pop -> no overflow, fifo_count stays at DEPTH, new character sent last.

Source files
------------

// File: rtl/hnsn_pkg.sv
// Shared definitions for the spike-decoder character path: FSM state type, ASCII constants, default baud divisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hnsn_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;

    // Serializer states; PARITY only exists when the parity build is selected.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef CHAR_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/char_fifo.sv
// Character FIFO: power-of-2 depth, wrapping pointers, full/empty derived from the occupancy count.
// Latency: a push is visible in count at the same edge; head data is combinational from the read pointer.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A write into a full FIFO is legal only when the head leaves at the same edge.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Occupancy changes only when exactly one of read/write happens.
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care after reset because the pointers restart.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/char_uart_tx.sv
// Queues decoded characters and serializes them as 8N1 UART frames (8E1 when CHAR_UART_TX_PARITY_EN is defined).
// Latency: start bit appears one clock after the push edge when idle and empty; one idle cycle between back-to-back frames.
// Backpressure: none upstream; a push into a full FIFO with no concurrent pop is dropped and sets the sticky overflow.
module char_uart_tx
    import hnsn_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int CHANGE_ONLY  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    input  logic                          char_changed,
    input  logic                          ovf_clr,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q;
    logic [7:0]  shreg_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic        uart_tx_q;
    logic        tx_busy_q;
    logic        ovf_q;
    logic        ovf_d;
`ifdef CHAR_UART_TX_PARITY_EN
    logic        par_q;
`endif

    logic        push_req;
    logic        pop_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        drop;
    logic        bit_done;

    assign push_req = char_valid && ((CHANGE_ONLY != 0) ? char_changed : 1'b1);
    assign pop_req  = (state_q == ST_IDLE) && !fifo_empty;
    assign drop     = push_req && fifo_full && !pop_req;
    assign bit_done = (baud_q == BAUD_LAST);

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat (char_in),
        .pop      (pop_req),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    // Frame FSM: each state holds its bit for CLKS_PER_BIT cycles; line and busy are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            uart_tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
`ifdef CHAR_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_req) begin
                        shreg_q   <= fifo_head;
`ifdef CHAR_UART_TX_PARITY_EN
                        par_q     <= ^fifo_head;
`endif
                        baud_q    <= '0;
                        uart_tx_q <= 1'b0;
                        tx_busy_q <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        baud_q    <= '0;
                        bit_q     <= '0;
                        uart_tx_q <= shreg_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef CHAR_UART_TX_PARITY_EN
                            uart_tx_q <= par_q;
                            state_q   <= ST_PARITY;
`else
                            uart_tx_q <= 1'b1;
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_q     <= bit_q + 3'd1;
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            uart_tx_q <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`ifdef CHAR_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        baud_q    <= '0;
                        uart_tx_q <= 1'b1;
                        state_q   <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        baud_q    <= '0;
                        tx_busy_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    uart_tx_q <= 1'b1;
                    tx_busy_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx  = uart_tx_q;
    assign tx_busy  = tx_busy_q;
    assign overflow = ovf_q;

endmodule
